riscv_instr_encoder: RTL
========================

# riscv_instr_encoder

Streaming instruction encoder: the write side of the opcode/instruction-format definitions used by the decode stage. It accepts field-level instruction requests and emits encoded 32-bit RV32 instruction words. It also expands the `LI` pseudo-instruction into one or two words. It feeds the debug program-buffer builder and the self-test program generator, and drives a valid/ready word stream.

## Interface
- `XLEN`, 32 — data width; only 32 is supported.
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — request accepted when `req_valid & req_ready`.
- `req_fmt` in 3 — 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LI, 7 NOP.
- `req_opc` in 5 — opcode bits [6:2]; bits [1:0] are forced to 2'b11. Ignored for LI and NOP.
- `req_f3` in 3 — funct3.
- `req_f7` in 7 — funct7, used for R format only.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each — register indices.
- `req_imm` in 32 — signed immediate; a byte offset for B and J. For U it is the 20-bit upper value in bits [19:0].
- `ins_valid` out 1 — encoded word valid.
- `ins_ready` in 1 — downstream accepts the word.
- `ins` out 32 — encoded instruction.
- `ins_last` out 1 — final word of the current request.
- `err` out 1 — one-cycle pulse: the request was rejected.

## Operation
- **Field placement** follows the base ISA formats exactly. `rd`=[11:7], `f3`=[14:12], `rs1`=[19:15], `rs2`=[24:20], `f7`=[31:25].
- **I/S immediate** is imm[11:0] and must sign-fit 12 bits.
- **B immediate** must sign-fit 13 bits and be even.
- **J immediate** must sign-fit 21 bits and be even.
- **Range violation**: the request is consumed, `err` pulses, and no word is emitted.
- **NOP** emits 0x00000013.
- **LI rd, imm**:
  - If imm sign-fits 12 bits, emit `ADDI rd,x0,imm`.
  - Otherwise compute `hi=(imm+0x800)>>12` (mod 2^32, 20 bits) and `lo=imm[11:0]`.
  - Emit `LUI rd,hi`.
  - If `lo!=0`, also emit `ADDI rd,rd,sext(lo)`.
- **FSM states**:
  - IDLE → IDLE on a one-word request.
  - IDLE → EMIT2 on LI needing ADDI after LUI. The second word and its fields are captured at acceptance.
  - EMIT2 → IDLE when the second word is loaded into the output register.
- **`req_ready`** = `(state==IDLE) & (!ins_valid | ins_ready)`.
- **`ins_last`** is 1 for every single-word output and for the second LI word; it is 0 for a LUI that is followed by an ADDI.

## Timing
- **Reset values**: state IDLE; `ins_valid`=0, `ins`=0, `ins_last`=0, `err`=0; `req_ready`=0 in the reset cycle, 1 from the next cycle.
- **Latency**: a request accepted in cycle N presents its first word in cycle N+1. For two-word LI, the second word follows in the cycle after the first handshake.
- **Throughput**: one single-word request per cycle while `ins_ready`=1.
- **Stream rules**:
  - `ins`, `ins_last` and `ins_valid` are held stable while `ins_valid & !ins_ready`.
  - `ins_valid` is never withdrawn without a handshake.
- **Error timing**: `err` is asserted in cycle N+1 only, with `ins_valid` unaffected for that request. An earlier word may still be held.
- **Reset mid-LI** (state EMIT2) drops the pending ADDI and clears `ins_valid`.
- **Simultaneous handshakes**: an output handshake and a request acceptance in the same cycle are legal and lose no word.

## Structure
- The shared opcodes package gains:
  - `fmt_t` enum (R…NOP);
  - `OPC_OP_IMM`/`OPC_LUI` used by the LI expansion;
  - `INSTR_NOP`.
- One sub-module is natural: `riscv_instr_pack`, purely combinational, mapping (fmt, fields, imm) to {word, range_err}. The FSM and output register stay in the top module.

## Test plan
- `ADDI x1,x0,5` (fmt I, opc 00100) → `ins`=0x00500093, `ins_last`=1, one cycle after acceptance.
- `ADD x3,x1,x2` (R, opc 01100); `BEQ x1,x2,+8` (B); `JAL x1,+2048` (J) → 0x002081B3, 0x00208463, 0x001000EF.
- LI cases:
  - LI x5,0x12345FFF → 0x123462B7 (`last`=0), then 0xFFF28293 (`last`=1).
  - LI x5,0x12345000 → 0x123452B7 only.
  - LI x1,-7 → a single ADDI, 0xFF900093.
- B imm=7, and I imm=4096 → `err` pulse each, no `ins_valid`, next request proceeds normally.
- `ins_ready` held 0 for 5 cycles during a two-word LI → word stable, `req_ready`=0 throughout, no word lost or duplicated. Then a back-to-back stream of 8 NOPs with `ins_ready`=1 → 8 words in 8 consecutive cycles.
- `rst` asserted in state EMIT2 → next cycle `ins_valid`=0 and state IDLE; a following request encodes correctly.

Source files
------------

// File: rtl/riscv_instr_encoder_pkg.sv
// Shared RV32 opcode / instruction-format definitions for the encoder slice.
// Provides the request format enum, the opcodes the LI expansion needs, the
// canonical NOP word and a signed-range helper used by the immediate checks.
package riscv_instr_encoder_pkg;

  // Request format codes, as driven on req_fmt.
  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtLi  = 3'd6,
    FmtNop = 3'd7
  } fmt_t;

  // Opcode bits [6:2]; bits [1:0] are always 2'b11 for 32-bit encodings.
  localparam logic [4:0]  OPC_OP_IMM = 5'b00100;
  localparam logic [4:0]  OPC_LUI    = 5'b01101;

  // ADDI x0, x0, 0
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  // True when v, read as a signed 32-bit value, is representable in `bits`
  // bits two's complement: everything from bit (bits-1) upward is a copy of
  // the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/riscv_instr_pack.sv
// Purely combinational field packer: maps a format code plus fields and
// immediate to a 32-bit RV32 word and a range-error flag.
// Ports:
//   fmt_i        request format (LI / NOP both yield the NOP word here; LI
//                expansion is handled by the caller)
//   opc_i        opcode bits [6:2]
//   f3_i, f7_i   funct3 / funct7
//   rd_i, rs1_i, rs2_i  register indices
//   imm_i        signed immediate (byte offset for B/J, upper 20 bits for U)
//   word_o       encoded instruction
//   range_err_o  immediate out of range or misaligned for the format
module riscv_instr_pack
  import riscv_instr_encoder_pkg::*;
(
  input  fmt_t        fmt_i,
  input  logic [4:0]  opc_i,
  input  logic [2:0]  f3_i,
  input  logic [6:0]  f7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_err_o
);

  logic [6:0] op;

  always_comb begin
    op          = {opc_i, 2'b11};
    word_o      = INSTR_NOP;
    range_err_o = 1'b0;
    unique case (fmt_i)
      FmtR: word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, op};
      FmtI: begin
        word_o      = {imm_i[11:0], rs1_i, f3_i, rd_i, op};
        range_err_o = !fits_signed(imm_i, 12);
      end
      FmtS: begin
        word_o      = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op};
        range_err_o = !fits_signed(imm_i, 12);
      end
      FmtB: begin
        word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                       imm_i[4:1], imm_i[11], op};
        range_err_o = !fits_signed(imm_i, 13) || imm_i[0];
      end
      FmtU: word_o = {imm_i[19:0], rd_i, op};
      FmtJ: begin
        word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op};
        range_err_o = !fits_signed(imm_i, 21) || imm_i[0];
      end
      default: word_o = INSTR_NOP;
    endcase
  end

endmodule

// File: rtl/riscv_instr_encoder.sv
// Streaming RV32 instruction encoder. Accepts field-level requests on a
// valid/ready port and emits encoded words on a valid/ready stream, expanding
// the LI pseudo-instruction into ADDI or LUI[+ADDI].
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_fmt                   0 R,1 I,2 S,3 B,4 U,5 J,6 LI,7 NOP
//   req_opc/f3/f7/rd/rs1/rs2  instruction fields
//   req_imm                   signed immediate
//   ins_valid/ins_ready/ins   encoded word stream
//   ins_last                  final word of the current request
//   err                       one-cycle pulse for a rejected request
module riscv_instr_encoder
  import riscv_instr_encoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_fmt,
  input  logic [4:0]      req_opc,
  input  logic [2:0]      req_f3,
  input  logic [6:0]      req_f7,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins,
  output logic            ins_last,
  output logic            err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_EMIT2 = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] ins_q, ins_d;
  logic        ins_valid_q, ins_valid_d;
  logic        ins_last_q, ins_last_d;
  logic        err_q, err_d;
  logic [31:0] pend_q, pend_d;

  fmt_t        fmt;
  logic [31:0] pack_word;
  logic        pack_err;

  logic        li_small;
  logic [31:0] li_round;
  logic [31:0] li_first;
  logic [31:0] li_second;
  logic        li_two;
  logic [31:0] first_word;
  logic        needs_two;

  logic        accept;
  logic        load_ok;

  assign fmt = fmt_t'(req_fmt);

  riscv_instr_pack u_pack (
    .fmt_i       (fmt),
    .opc_i       (req_opc),
    .f3_i        (req_f3),
    .f7_i        (req_f7),
    .rd_i        (req_rd),
    .rs1_i       (req_rs1),
    .rs2_i       (req_rs2),
    .imm_i       (req_imm),
    .word_o      (pack_word),
    .range_err_o (pack_err)
  );

  // LI expansion. Adding 0x800 before taking the upper 20 bits compensates
  // for the sign extension of the low 12 bits by the trailing ADDI.
  always_comb begin
    li_small  = fits_signed(req_imm, 12);
    li_round  = req_imm + 32'h0000_0800;
    li_first  = li_small ? {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OP_IMM, 2'b11}
                         : {li_round[31:12], req_rd, OPC_LUI, 2'b11};
    li_second = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_OP_IMM, 2'b11};
    li_two    = !li_small && (req_imm[11:0] != 12'd0);

    if (fmt == FmtLi) begin
      first_word = li_first;
      needs_two  = li_two;
    end else begin
      first_word = pack_word;
      needs_two  = 1'b0;
    end
  end

  // Output register may be (re)loaded when empty or being drained this cycle.
  assign load_ok   = !ins_valid_q || ins_ready;
  assign req_ready = !rst && (state_q == ST_IDLE) && load_ok;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    ins_last_d  = ins_last_q;
    pend_d      = pend_q;
    err_d       = 1'b0;

    if (ins_valid_q && ins_ready) begin
      ins_valid_d = 1'b0;
    end

    if (state_q == ST_EMIT2) begin
      if (load_ok) begin
        ins_d       = pend_q;
        ins_valid_d = 1'b1;
        ins_last_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    end else if (accept) begin
      // LI never raises pack_err since the packer treats it as NOP.
      if (pack_err) begin
        err_d = 1'b1;
      end else begin
        ins_d       = first_word;
        ins_valid_d = 1'b1;
        ins_last_d  = !needs_two;
        if (needs_two) begin
          pend_d  = li_second;
          state_d = ST_EMIT2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      ins_last_q  <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      ins_last_q  <= ins_last_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
    end
  end

  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign ins_last  = ins_last_q;
  assign err       = err_q;

endmodule
